soc_addr_router: RTL and testbench
==================================

# soc_addr_router

Address-decode and routing stage that sits directly upstream of the SoC crossbar slave ports. It registers each core-side request, decodes its 64-bit address against the fixed SoC address map into a one-hot slave select, and forwards mapped requests downstream. Unmapped requests get a locally generated decode-error response, ordered behind all outstanding mapped transactions. It also limits the number of in-flight transactions.

## Interface
- `IdWidth`, default 4: transaction ID width.
- `MaxOutstanding`, default 8: maximum number of mapped requests in flight; range 1..255.
- `NumRegions`, default 12: number of map regions. Fixed at 12; other values are unsupported.

Ports. One clock; reset is synchronous and active-high.
- `clk_i` in 1: clock.
- `rst_i` in 1: synchronous, active-high reset.
- `req_valid_i` in 1 / `req_ready_o` out 1: request handshake.
- `req_addr_i` in 64: request address.
- `req_we_i` in 1: write flag.
- `req_id_i` in IdWidth: request ID.
- `out_valid_o` out 1 / `out_ready_i` in 1: downstream request handshake.
- `out_sel_o` out 12: one-hot slave select, bit index = region index.
- `out_addr_o` out 64, `out_we_o` out 1, `out_id_o` out IdWidth: registered copies of the request fields.
- `slv_rsp_valid_i` in 1 / `slv_rsp_ready_o` out 1: slave response handshake.
- `slv_rsp_id_i` in IdWidth, `slv_rsp_err_i` in 1: slave response fields.
- `rsp_valid_o` out 1 / `rsp_ready_i` in 1: upstream response handshake.
- `rsp_id_o` out IdWidth, `rsp_err_o` out 1: upstream response fields.
- `outstanding_o` out 8: current number of in-flight mapped requests.
- `decerr_cnt_o` out 16: count of decode errors, saturating.

## Operation
- **Address map.** Region i matches when base ≤ addr < base + length. The 65-bit sum must not wrap. Regions as index: base, length:
  - DRAM 0: 0x180_0000_0000, 0x1_FFBF_FFFF.
  - GPIO 1: 0x4000_0000, 0x1000.
  - Ethernet 2: 0x3000_0000, 0x10000.
  - SPI 3: 0x101_00C0_0000, 0xFF.
  - Timer 4: 0x1800_0000, 0x1000.
  - UART 5: 0x1000_0000, 0x1000.
  - PLIC 6: 0x0C00_0000, 0x3FF_FFFF.
  - CLINT 7: 0x0200_0000, 0xC0000.
  - ROM 8: 0x101_0000_0000, 0x3F_FFFF.
  - Debug 9: 0x0, 0x1000.
  - HPS 10: 0xFF80_0000, 0x80_0000.
  - LSM 11: 0x101_0400_0000, 0x07FF_FFFF.
  - If several regions match, the lowest index wins. No match means unmapped.
- **Stage register.** One entry holding valid, addr, we, id, sel, unmapped.
  - `req_ready_o` = !valid, or the entry leaves this cycle.
  - Decode is computed combinationally on `req_addr_i` and captured with the request.
- **Mapped path.**
  - `out_valid_o` = entry valid & !unmapped & (`outstanding_o` < MaxOutstanding).
  - The entry leaves on `out_valid_o` & `out_ready_i`, and `outstanding_o` increments.
- **Response path.**
  - `slv_rsp_ready_o` = `rsp_ready_i` whenever the error FSM is not in RESP.
  - Slave responses pass combinationally to `rsp_*`.
  - Each slave response handshake decrements `outstanding_o`.
  - An issue and a return in the same cycle leave the count unchanged.
- **Error FSM** (IDLE, DRAIN, RESP):
  - IDLE: an unmapped entry moves to DRAIN, or straight to RESP if `outstanding_o` == 0, or will be 0 after this cycle's return.
  - DRAIN: move to RESP when `outstanding_o` reaches 0.
  - RESP: drive `rsp_valid_o`=1, `rsp_err_o`=1, `rsp_id_o`=entry id. On `rsp_ready_i`, free the entry, increment `decerr_cnt_o` (saturating at 0xFFFF) and return to IDLE.
- **Ordering.** Responses return upstream in request order: an error response never overtakes mapped transactions.
- **Reset.** All outputs are 0 after reset:
  - stage empty, FSM in IDLE, counters 0;
  - `req_ready_o`=1;
  - `out_sel_o`=0, `rsp_valid_o`=0.
- Reset asserted mid-operation discards the entry and in-flight tracking. Responses arriving after reset still pass through but must not decrement the count below 0 (clamped).

## Timing
- **Latency.** Request accepted at cycle N gives `out_valid_o` at N+1, when the outstanding limit allows.
- **Throughput.** One mapped request per cycle with `out_ready_i`=1 and the limit not reached.
- **Decode error.** Accepted at N with nothing outstanding gives `rsp_valid_o` at N+1.
- **Limit reached.** At `outstanding_o`=MaxOutstanding, `out_valid_o`=0 and the entry is held. A return in cycle M allows issue in cycle M+1.
- **Held outputs.** `out_*` and error `rsp_*` hold stable while valid and not ready.

## Test plan
- **Mapped request.** Request 0x1000_0010 (UART) with `out_ready_i`=1 -> `out_sel_o`=0x020 at N+1, `outstanding_o`=1. Slave response id 3, err=0 -> `rsp_id_o`=3, `rsp_err_o`=0, `outstanding_o`=0.
- **Region boundaries.**
  - 0x0FFF -> Debug (0x200).
  - 0x1000 -> decode error.
  - 0x101_00C0_00FE -> SPI (0x008).
  - 0x101_00C0_00FF -> decode error.
  - 0xFFFF_FFFF -> HPS (0x400).
- **Error ordering.** Issue 3 DRAM requests, then request 0x5000_0000 id 7 -> the FSM waits in DRAIN. After the third slave response, `rsp_valid_o`=1, err=1, id=7. `decerr_cnt_o`=1.
- **Outstanding limit.** MaxOutstanding=2: 3 back-to-back GPIO requests -> the third is held with `out_valid_o`=0 until the first response, then issued the next cycle. `req_ready_o`=0 while held.
- **Backpressure.** Hold `out_ready_i`=0 for 5 cycles -> `out_addr_o`/`out_sel_o` stay stable and `req_ready_o`=0. Hold `rsp_ready_i`=0 during RESP -> the error response stays stable.
- **Reset mid-flight.** `rst_i` pulsed with 2 outstanding and the stage full -> next cycle all outputs are 0, `req_ready_o`=1, and late slave responses leave `outstanding_o` at 0.

Source files
------------

// File: rtl/soc_addr_router.sv
// soc_addr_router: registers core requests, decodes them against the fixed SoC address map,
// forwards mapped requests and answers unmapped ones with a decode error ordered behind in-flight traffic.
module soc_addr_router #(
    parameter int IdWidth        = 4,
    parameter int MaxOutstanding = 8,
    parameter int NumRegions     = 12
) (
    input  logic                  clk_i,
    input  logic                  rst_i,

    input  logic                  req_valid_i,
    output logic                  req_ready_o,
    input  logic [63:0]           req_addr_i,
    input  logic                  req_we_i,
    input  logic [IdWidth-1:0]    req_id_i,

    output logic                  out_valid_o,
    input  logic                  out_ready_i,
    output logic [NumRegions-1:0] out_sel_o,
    output logic [63:0]           out_addr_o,
    output logic                  out_we_o,
    output logic [IdWidth-1:0]    out_id_o,

    input  logic                  slv_rsp_valid_i,
    output logic                  slv_rsp_ready_o,
    input  logic [IdWidth-1:0]    slv_rsp_id_i,
    input  logic                  slv_rsp_err_i,

    output logic                  rsp_valid_o,
    input  logic                  rsp_ready_i,
    output logic [IdWidth-1:0]    rsp_id_o,
    output logic                  rsp_err_o,

    output logic [7:0]            outstanding_o,
    output logic [15:0]           decerr_cnt_o
);

    // Region table, index order = priority order (lowest index wins on overlap).
    localparam logic [63:0] region_base [NumRegions] = '{
        64'h0000_0180_0000_0000,  // DRAM
        64'h0000_0000_4000_0000,  // GPIO
        64'h0000_0000_3000_0000,  // Ethernet
        64'h0000_0101_00C0_0000,  // SPI
        64'h0000_0000_1800_0000,  // Timer
        64'h0000_0000_1000_0000,  // UART
        64'h0000_0000_0C00_0000,  // PLIC
        64'h0000_0000_0200_0000,  // CLINT
        64'h0000_0101_0000_0000,  // ROM
        64'h0000_0000_0000_0000,  // Debug
        64'h0000_0000_FF80_0000,  // HPS
        64'h0000_0101_0400_0000   // LSM
    };

    localparam logic [63:0] region_len [NumRegions] = '{
        64'h0000_0001_FFBF_FFFF,
        64'h0000_0000_0000_1000,
        64'h0000_0000_0001_0000,
        64'h0000_0000_0000_00FF,
        64'h0000_0000_0000_1000,
        64'h0000_0000_0000_1000,
        64'h0000_0000_03FF_FFFF,
        64'h0000_0000_000C_0000,
        64'h0000_0000_003F_FFFF,
        64'h0000_0000_0000_1000,
        64'h0000_0000_0080_0000,
        64'h0000_0000_07FF_FFFF
    };

    typedef enum logic [1:0] {
        st_idle,
        st_drain,
        st_resp
    } err_state_e;

    typedef struct packed {
        logic                  valid;
        logic [63:0]           addr;
        logic                  we;
        logic [IdWidth-1:0]    id;
        logic [NumRegions-1:0] sel;
        logic                  unmapped;
    } entry_t;

    entry_t                entry_q;
    err_state_e            state_q, state_d;
    logic [7:0]            cnt_q, cnt_d;
    logic [15:0]           decerr_q;

    logic [NumRegions-1:0] dec_match;
    logic [NumRegions-1:0] dec_sel;
    logic                  dec_unmapped;

    logic                  req_fire;
    logic                  out_fire;
    logic                  slv_fire;
    logic                  err_fire;
    logic                  entry_leave;

    // Address decode on the incoming request; sums are 65 bits wide so a region end never wraps.
    // NOTE: every signal assigned in an always_comb gets a default first, so no path can infer a latch.
    always_comb begin
        dec_match = '0;
        for (int i = 0; i < NumRegions; i++) begin
            if (({1'b0, req_addr_i} >= {1'b0, region_base[i]}) &&
                ({1'b0, req_addr_i} <  ({1'b0, region_base[i]} + {1'b0, region_len[i]}))) begin
                dec_match[i] = 1'b1;
            end
        end
    end

    // Isolate the lowest set bit: that is the highest-priority matching region.
    assign dec_sel      = dec_match & (~dec_match + {{(NumRegions-1){1'b0}}, 1'b1});
    assign dec_unmapped = ~|dec_match;

    // Handshakes.
    assign out_valid_o = entry_q.valid & ~entry_q.unmapped & (cnt_q < 8'(MaxOutstanding));
    assign out_fire    = out_valid_o & out_ready_i;
    assign slv_fire    = slv_rsp_valid_i & slv_rsp_ready_o;
    assign err_fire    = (state_q == st_resp) & rsp_ready_i;
    assign entry_leave = out_fire | err_fire;
    assign req_ready_o = ~entry_q.valid | entry_leave;
    assign req_fire    = req_valid_i & req_ready_o;

    assign out_sel_o     = entry_q.sel;
    assign out_addr_o    = entry_q.addr;
    assign out_we_o      = entry_q.we;
    assign out_id_o      = entry_q.id;
    assign outstanding_o = cnt_q;
    assign decerr_cnt_o  = decerr_q;

    // NOTE: the stage is a few flops that drive outputs, not a memory, so every field is reset.
    // NOTE: sequential state is written with non-blocking assignments only.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            entry_q <= '0;
        end else if (req_fire) begin
            entry_q <= '{valid:    1'b1,
                         addr:     req_addr_i,
                         we:       req_we_i,
                         id:       req_id_i,
                         sel:      dec_sel,
                         unmapped: dec_unmapped};
        end else if (entry_leave) begin
            entry_q.valid <= 1'b0;
        end
    end

    // In-flight count; a return with nothing tracked (stale after reset) is ignored.
    always_comb begin
        cnt_d = cnt_q;
        if (out_fire && !slv_fire) begin
            cnt_d = cnt_q + 8'd1;
        end else if (!out_fire && slv_fire && (cnt_q != 8'd0)) begin
            cnt_d = cnt_q - 8'd1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= 8'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            decerr_q <= 16'd0;
        end else if (err_fire && (decerr_q != 16'hFFFF)) begin
            decerr_q <= decerr_q + 16'd1;
        end
    end

    // Error FSM: state register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= st_idle;
        end else begin
            state_q <= state_d;
        end
    end

    // Error FSM: next state. An unmapped request is classified as it is captured, so with
    // nothing in flight its error response appears the very next cycle.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            st_idle: begin
                if (req_fire && dec_unmapped) begin
                    state_d = (cnt_d == 8'd0) ? st_resp : st_drain;
                end
            end
            st_drain: begin
                if (cnt_d == 8'd0) begin
                    state_d = st_resp;
                end
            end
            st_resp: begin
                if (rsp_ready_i) begin
                    if (req_fire && dec_unmapped) begin
                        state_d = (cnt_d == 8'd0) ? st_resp : st_drain;
                    end else begin
                        state_d = st_idle;
                    end
                end
            end
            default: state_d = st_idle;
        endcase
    end

    // Error FSM: outputs. Outside RESP the slave response channel passes straight through.
    always_comb begin
        rsp_valid_o     = slv_rsp_valid_i;
        rsp_id_o        = slv_rsp_id_i;
        rsp_err_o       = slv_rsp_err_i;
        slv_rsp_ready_o = rsp_ready_i;
        if (state_q == st_resp) begin
            rsp_valid_o     = 1'b1;
            rsp_id_o        = entry_q.id;
            rsp_err_o       = 1'b1;
            slv_rsp_ready_o = 1'b0;
        end
    end

    // Protocol properties for simulation.
    a_out_hold: assert property (@(posedge clk_i) disable iff (rst_i)
        out_valid_o && !out_ready_i |=> out_valid_o && $stable(out_addr_o) && $stable(out_sel_o));

    a_err_hold: assert property (@(posedge clk_i) disable iff (rst_i)
        (state_q == st_resp) && !rsp_ready_i |=> (state_q == st_resp) && $stable(rsp_id_o));

    a_limit: assert property (@(posedge clk_i) disable iff (rst_i)
        cnt_q <= 8'(MaxOutstanding));

    a_sel_onehot: assert property (@(posedge clk_i) disable iff (rst_i)
        $onehot0(out_sel_o));

endmodule

// File: tb/tb_soc_addr_router.sv
// tb_soc_addr_router: decode table, directed ordering/limit/backpressure/reset sequences,
// and randomized traffic against a transaction-level reference model.
module tb_soc_addr_router;

    localparam int ID_W    = 4;
    localparam int MAX_OUT = 3;
    localparam int N_RAND  = 1500;
    localparam int NV      = 15;

    logic            clk_i = 1'b0;
    logic            rst_i = 1'b1;
    logic            req_valid_i, req_ready_o, req_we_i;
    logic [63:0]     req_addr_i;
    logic [ID_W-1:0] req_id_i;
    logic            out_valid_o, out_ready_i, out_we_o;
    logic [11:0]     out_sel_o;
    logic [63:0]     out_addr_o;
    logic [ID_W-1:0] out_id_o;
    logic            slv_rsp_valid_i, slv_rsp_ready_o, slv_rsp_err_i;
    logic [ID_W-1:0] slv_rsp_id_i;
    logic            rsp_valid_o, rsp_ready_i, rsp_err_o;
    logic [ID_W-1:0] rsp_id_o;
    logic [7:0]      outstanding_o;
    logic [15:0]     decerr_cnt_o;

    always #5 clk_i = ~clk_i;

    soc_addr_router #(
        .IdWidth(ID_W),
        .MaxOutstanding(MAX_OUT),
        .NumRegions(12)
    ) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_addr_i(req_addr_i),
        .req_we_i(req_we_i), .req_id_i(req_id_i),
        .out_valid_o(out_valid_o), .out_ready_i(out_ready_i), .out_sel_o(out_sel_o),
        .out_addr_o(out_addr_o), .out_we_o(out_we_o), .out_id_o(out_id_o),
        .slv_rsp_valid_i(slv_rsp_valid_i), .slv_rsp_ready_o(slv_rsp_ready_o),
        .slv_rsp_id_i(slv_rsp_id_i), .slv_rsp_err_i(slv_rsp_err_i),
        .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i), .rsp_id_o(rsp_id_o),
        .rsp_err_o(rsp_err_o),
        .outstanding_o(outstanding_o), .decerr_cnt_o(decerr_cnt_o)
    );

    // SoC map as the reference model sees it.
    logic [63:0] rg_base [12] = '{64'h180_0000_0000, 64'h4000_0000, 64'h3000_0000, 64'h101_00C0_0000,
                                  64'h1800_0000, 64'h1000_0000, 64'h0C00_0000, 64'h0200_0000,
                                  64'h101_0000_0000, 64'h0, 64'hFF80_0000, 64'h101_0400_0000};
    logic [63:0] rg_len  [12] = '{64'h1_FFBF_FFFF, 64'h1000, 64'h10000, 64'hFF,
                                  64'h1000, 64'h1000, 64'h3FF_FFFF, 64'hC0000,
                                  64'h3F_FFFF, 64'h1000, 64'h80_0000, 64'h07FF_FFFF};

    typedef struct {
        logic [63:0] addr;
        logic [11:0] sel;
        logic        unmapped;
    } vec_t;

    typedef struct {
        logic [63:0]     addr;
        logic            we;
        logic [ID_W-1:0] id;
        logic [11:0]     sel;
    } req_t;

    vec_t            vecs [NV];
    req_t            exp_out_q [$];
    logic [5:0]      exp_rsp_q [$];   // {unmapped, id, err}
    logic [ID_W-1:0] slv_q [$];
    int              n_tests = 0;
    int              n_fail  = 0;
    int              model_cnt;
    logic [15:0]     exp_decerr;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        @(negedge clk_i);
    endtask

    task automatic idle_inputs();
        req_valid_i     = 1'b0;
        req_addr_i      = '0;
        req_we_i        = 1'b0;
        req_id_i        = '0;
        out_ready_i     = 1'b1;
        slv_rsp_valid_i = 1'b0;
        slv_rsp_id_i    = '0;
        slv_rsp_err_i   = 1'b0;
        rsp_ready_i     = 1'b1;
    endtask

    task automatic send_req(input logic [63:0] a, input logic w, input logic [ID_W-1:0] id);
        req_valid_i = 1'b1;
        req_addr_i  = a;
        req_we_i    = w;
        req_id_i    = id;
        #1;
        for (int c = 0; c < 50 && !req_ready_o; c++) begin
            step();
            #1;
        end
        check("req_accept", 128'(req_ready_o), 128'(1));
        step();
        req_valid_i = 1'b0;
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, "_outputs"},
              128'({out_valid_o, out_sel_o, out_addr_o, out_we_o, out_id_o, rsp_valid_o, rsp_err_o,
                    rsp_id_o, outstanding_o, decerr_cnt_o}), 128'(0));
        check({tag, "_req_ready"}, 128'(req_ready_o), 128'(1));
    endtask

    // First region (lowest index) whose [base, base+len) holds the address; 0 when unmapped.
    function automatic logic [11:0] model_sel(input logic [63:0] a);
        for (int i = 0; i < 12; i++) begin
            if ({1'b0, a} >= {1'b0, rg_base[i]} && {1'b0, a} < {1'b0, rg_base[i]} + {1'b0, rg_len[i]})
                return 12'(1) << i;
        end
        return 12'h000;
    endfunction

    function automatic logic [63:0] rand_addr();
        int          r;
        logic [63:0] b, l;
        r = $urandom_range(0, 15);
        if (r >= 12) return {$urandom(), $urandom()};
        b = rg_base[r];
        l = rg_len[r];
        case ($urandom_range(0, 4))
            0:       return b;
            1:       return b + l - 64'd1;
            2:       return b + l;
            3:       return b - 64'd1;
            default: return b + ({$urandom(), $urandom()} % l);
        endcase
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no completion, want completion within 1 ms");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [11:0] rsel;
        logic [5:0]  er;
        req_t        e;
        logic        rq_f, out_f, slv_f;

        vecs[0]  = '{64'h1000_0010,     12'h020, 1'b0};
        vecs[1]  = '{64'h0FFF,          12'h200, 1'b0};
        vecs[2]  = '{64'h1000,          12'h000, 1'b1};
        vecs[3]  = '{64'h101_00C0_00FE, 12'h008, 1'b0};
        vecs[4]  = '{64'h101_00C0_00FF, 12'h000, 1'b1};
        vecs[5]  = '{64'hFFFF_FFFF,     12'h400, 1'b0};
        vecs[6]  = '{64'h180_0000_0000, 12'h001, 1'b0};
        vecs[7]  = '{64'h181_FFBF_FFFE, 12'h001, 1'b0};
        vecs[8]  = '{64'h181_FFBF_FFFF, 12'h000, 1'b1};
        vecs[9]  = '{64'h0C00_0000,     12'h040, 1'b0};
        vecs[10] = '{64'h0200_0000,     12'h080, 1'b0};
        vecs[11] = '{64'h101_0400_0000, 12'h800, 1'b0};
        vecs[12] = '{64'h3000_FFFF,     12'h004, 1'b0};
        vecs[13] = '{64'h1800_0FFF,     12'h010, 1'b0};
        vecs[14] = '{64'h101_0000_0000, 12'h100, 1'b0};

        idle_inputs();
        exp_decerr = 16'd0;
        rst_i = 1'b1;
        repeat (3) @(negedge clk_i);
        rst_i = 1'b0;
        #1;
        check_zero_outputs("reset");

        // Decode table: one request at a time, mapped ones answered by the slave.
        for (int k = 0; k < NV; k++) begin
            req_valid_i = 1'b1;
            req_addr_i  = vecs[k].addr;
            req_we_i    = k[0];
            req_id_i    = k[3:0];
            #1;
            check($sformatf("tbl%0d_ready", k), 128'(req_ready_o), 128'(1));
            step();
            req_valid_i = 1'b0;
            #1;
            if (!vecs[k].unmapped) begin
                check($sformatf("tbl%0d_out", k),
                      128'({out_valid_o, rsp_valid_o, out_sel_o, out_addr_o, out_we_o, out_id_o}),
                      128'({1'b1, 1'b0, vecs[k].sel, vecs[k].addr, k[0], k[3:0]}));
                step();
                #1;
                check($sformatf("tbl%0d_cnt1", k), 128'(outstanding_o), 128'(1));
                slv_rsp_valid_i = 1'b1;
                slv_rsp_id_i    = k[3:0];
                slv_rsp_err_i   = k[1];
                #1;
                check($sformatf("tbl%0d_rsp", k),
                      128'({rsp_valid_o, rsp_id_o, rsp_err_o, slv_rsp_ready_o}),
                      128'({1'b1, k[3:0], k[1], 1'b1}));
                step();
                slv_rsp_valid_i = 1'b0;
                #1;
                check($sformatf("tbl%0d_cnt0", k), 128'(outstanding_o), 128'(0));
            end else begin
                check($sformatf("tbl%0d_err", k),
                      128'({out_valid_o, rsp_valid_o, rsp_err_o, rsp_id_o, slv_rsp_ready_o}),
                      128'({1'b0, 1'b1, 1'b1, k[3:0], 1'b0}));
                step();
                exp_decerr++;
                #1;
                check($sformatf("tbl%0d_done", k), 128'({rsp_valid_o, decerr_cnt_o}),
                      128'({1'b0, exp_decerr}));
            end
        end

        // Error ordering: decode error waits behind three DRAM transactions.
        send_req(64'h180_0000_0000, 1'b0, 4'd0);
        send_req(64'h180_0000_0040, 1'b1, 4'd1);
        send_req(64'h180_0000_0080, 1'b0, 4'd2);
        send_req(64'h5000_0000,     1'b0, 4'd7);
        #1;
        check("ord_drain", 128'({outstanding_o, rsp_valid_o, req_ready_o, out_valid_o}),
              128'({8'd3, 1'b0, 1'b0, 1'b0}));
        for (int r = 0; r < 3; r++) begin
            slv_rsp_valid_i = 1'b1;
            slv_rsp_id_i    = r[3:0];
            slv_rsp_err_i   = 1'b0;
            #1;
            check($sformatf("ord_pass%0d", r), 128'({rsp_valid_o, rsp_err_o, rsp_id_o}),
                  128'({1'b1, 1'b0, r[3:0]}));
            step();
            slv_rsp_valid_i = 1'b0;
        end
        rsp_ready_i = 1'b0;
        #1;
        check("ord_err", 128'({rsp_valid_o, rsp_err_o, rsp_id_o, outstanding_o}),
              128'({1'b1, 1'b1, 4'd7, 8'd0}));
        repeat (3) begin
            step();
            #1;
            check("ord_err_hold",
                  128'({rsp_valid_o, rsp_err_o, rsp_id_o, slv_rsp_ready_o, req_ready_o, decerr_cnt_o}),
                  128'({1'b1, 1'b1, 4'd7, 1'b0, 1'b0, exp_decerr}));
        end
        rsp_ready_i = 1'b1;
        #1;
        step();
        exp_decerr++;
        #1;
        check("ord_done", 128'({rsp_valid_o, decerr_cnt_o}), 128'({1'b0, exp_decerr}));

        // Outstanding limit: the fourth GPIO request is held until a return frees a slot.
        for (int g = 0; g < 4; g++) send_req(64'h4000_0000 + 64'(g * 4), 1'b0, 4'(g));
        #1;
        check("lim_held", 128'({out_valid_o, req_ready_o, outstanding_o, out_addr_o}),
              128'({1'b0, 1'b0, 8'd3, 64'h4000_000C}));
        repeat (2) begin
            step();
            #1;
            check("lim_still_held", 128'({out_valid_o, req_ready_o}), 128'(0));
        end
        slv_rsp_valid_i = 1'b1;
        slv_rsp_id_i    = 4'd0;
        #1;
        check("lim_ret_cycle", 128'(out_valid_o), 128'(0));
        step();
        slv_rsp_valid_i = 1'b0;
        #1;
        check("lim_issue", 128'({out_valid_o, outstanding_o, out_addr_o}),
              128'({1'b1, 8'd2, 64'h4000_000C}));
        step();
        #1;
        check("lim_full", 128'({out_valid_o, outstanding_o}), 128'({1'b0, 8'd3}));
        slv_rsp_valid_i = 1'b1;
        repeat (3) step();
        slv_rsp_valid_i = 1'b0;
        #1;
        check("lim_drained", 128'(outstanding_o), 128'(0));

        // Downstream backpressure: entry and select hold, no new request accepted.
        out_ready_i = 1'b0;
        send_req(64'h180_0000_1000, 1'b1, 4'd5);
        req_valid_i = 1'b1;
        req_addr_i  = 64'h1000_0000;
        repeat (5) begin
            #1;
            check("bp_hold", 128'({out_valid_o, req_ready_o, out_sel_o, out_addr_o, out_we_o, out_id_o}),
                  128'({1'b1, 1'b0, 12'h001, 64'h180_0000_1000, 1'b1, 4'd5}));
            step();
        end
        req_valid_i = 1'b0;
        out_ready_i = 1'b1;
        #1;
        step();
        #1;
        check("bp_issued", 128'({out_valid_o, outstanding_o}), 128'({1'b0, 8'd1}));
        slv_rsp_valid_i = 1'b1;
        slv_rsp_id_i    = 4'd5;
        step();
        slv_rsp_valid_i = 1'b0;
        #1;
        check("bp_drained", 128'(outstanding_o), 128'(0));

        // Randomized traffic against the transaction-level model.
        model_cnt = 0;
        for (int cyc = 0; cyc < N_RAND + 400; cyc++) begin
            if (cyc >= N_RAND && !req_valid_i && !slv_rsp_valid_i && exp_rsp_q.size() == 0 &&
                exp_out_q.size() == 0 && slv_q.size() == 0) break;
            if (!req_valid_i && cyc < N_RAND && $urandom_range(0, 2) != 0) begin
                req_valid_i = 1'b1;
                req_addr_i  = rand_addr();
                req_we_i    = 1'($urandom_range(0, 1));
                req_id_i    = 4'($urandom_range(0, 15));
            end
            out_ready_i = (cyc >= N_RAND) || ($urandom_range(0, 3) != 0);
            rsp_ready_i = (cyc >= N_RAND) || ($urandom_range(0, 3) != 0);
            if (!slv_rsp_valid_i && slv_q.size() > 0 && ((cyc >= N_RAND) || $urandom_range(0, 1) == 1)) begin
                slv_rsp_valid_i = 1'b1;
                slv_rsp_id_i    = slv_q[0];
                slv_rsp_err_i   = slv_q[0][0];
            end
            #1;
            check("rnd_outstanding", 128'(outstanding_o), 128'(model_cnt));
            rq_f  = req_valid_i && req_ready_o;
            out_f = out_valid_o && out_ready_i;
            slv_f = slv_rsp_valid_i && slv_rsp_ready_o;
            if (out_valid_o) check("rnd_limit", 128'(model_cnt < MAX_OUT), 128'(1));
            if (rq_f) begin
                rsel = model_sel(req_addr_i);
                if (rsel != 12'h000) exp_out_q.push_back('{req_addr_i, req_we_i, req_id_i, rsel});
                exp_rsp_q.push_back({rsel == 12'h000, req_id_i, (rsel == 12'h000) ? 1'b1 : req_id_i[0]});
            end
            if (out_f) begin
                if (exp_out_q.size() == 0) begin
                    check("rnd_out_unexpected", 128'(exp_out_q.size()), 128'(1));
                end else begin
                    e = exp_out_q.pop_front();
                    check("rnd_out", 128'({out_addr_o, out_we_o, out_id_o, out_sel_o}),
                          128'({e.addr, e.we, e.id, e.sel}));
                    slv_q.push_back(e.id);
                end
            end
            if (rsp_valid_o && rsp_ready_i) begin
                if (exp_rsp_q.size() == 0) begin
                    check("rnd_rsp_unexpected", 128'(exp_rsp_q.size()), 128'(1));
                end else begin
                    er = exp_rsp_q.pop_front();
                    check("rnd_rsp", 128'({rsp_id_o, rsp_err_o}), 128'(er[4:0]));
                    if (er[5]) exp_decerr++;
                end
            end
            if (slv_f) void'(slv_q.pop_front());
            model_cnt = model_cnt + (out_f ? 1 : 0) - (slv_f ? 1 : 0);
            step();
            if (rq_f)  req_valid_i = 1'b0;
            if (slv_f) slv_rsp_valid_i = 1'b0;
        end
        #1;
        check("rnd_drained", 128'(exp_rsp_q.size() + exp_out_q.size() + slv_q.size()), 128'(0));
        check("rnd_decerr", 128'({decerr_cnt_o, outstanding_o}), 128'({exp_decerr, 8'd0}));

        // Reset with two in flight and the stage full; late returns must not underflow.
        idle_inputs();
        send_req(64'h1000_0000, 1'b0, 4'd1);
        send_req(64'h1000_0004, 1'b0, 4'd2);
        send_req(64'h1000_0008, 1'b0, 4'd3);
        out_ready_i = 1'b0;
        #1;
        check("rst_pre", 128'({outstanding_o, out_valid_o, req_ready_o}), 128'({8'd2, 1'b1, 1'b0}));
        rst_i = 1'b1;
        step();
        rst_i = 1'b0;
        exp_decerr = 16'd0;
        #1;
        check_zero_outputs("rst_mid");
        for (int r = 1; r < 3; r++) begin
            slv_rsp_valid_i = 1'b1;
            slv_rsp_id_i    = r[3:0];
            #1;
            check($sformatf("rst_late%0d", r), 128'({rsp_valid_o, rsp_id_o}), 128'({1'b1, r[3:0]}));
            step();
        end
        slv_rsp_valid_i = 1'b0;
        #1;
        check("rst_clamp", 128'(outstanding_o), 128'(0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
